spi_eeprom_sequencer: RTL

Command sequencer directly upstream of the SPI byte engine. It turns one read or write request from the register/bus side into the byte frames a 25xx-series SPI EEPROM needs:
- Write: WREN frame, then WRITE frame (4 bytes).
- Read: READ frame (4 bytes).

It drives the byte engine's start/continued/txData inputs and consumes its ready/rxData outputs. One request is in flight at a time.

---
 rtl/spi_eeprom_pkg.sv | 32 +++
 rtl/spi_byte_handshake.sv | 74 +++++++
 rtl/spi_eeprom_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the SPI EEPROM command sequencer: 25xx opcodes,
// status-register bit positions and the state encodings of the sequencer
// and its byte handshake engine.
package spi_eeprom_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_WREN  = 8'h06;
    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_RDSR  = 8'h05;

    // Write-in-progress flag in the RDSR status byte
    localparam int unsigned WIP_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WREN  = 3'd1,
        ST_GAP   = 3'd2,
        ST_FRAME = 3'd3,
        ST_POLL  = 3'd4,
        ST_RESP  = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_ISSUE   = 2'd1,
        HS_WAIT_LO = 2'd2,
        HS_WAIT_HI = 2'd3
    } hs_state_t;

endpackage

// File: rtl/spi_byte_handshake.sv
// One-byte handshake with the SPI byte engine.
// A go pulse latches tx/cont; the engine then sees one byte_start pulse once
// it is ready, and done pulses (with rx valid) when it returns to ready.
// Ports: clk, rst (sync, active-high); go/tx/cont from the sequencer;
//        done/rx back to the sequencer; byte_start/byte_continued/byte_tx
//        to the engine; byte_rx/byte_ready from the engine.
module spi_byte_handshake
    import spi_eeprom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [BYTE_W-1:0] tx,
    input  logic              cont,
    output logic              done,
    output logic [BYTE_W-1:0] rx,
    output logic              byte_start,
    output logic              byte_continued,
    output logic [BYTE_W-1:0] byte_tx,
    input  logic [BYTE_W-1:0] byte_rx,
    input  logic              byte_ready
);

    hs_state_t state;
    hs_state_t state_next;
    logic      start_c;
    logic      done_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= HS_IDLE;
        else     state <= state_next;
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            HS_IDLE:    if (go)          state_next = HS_ISSUE;
            HS_ISSUE:   if (byte_ready)  state_next = HS_WAIT_LO;
            // byte_ready may already be low on the start cycle
            HS_WAIT_LO: if (!byte_ready) state_next = HS_WAIT_HI;
            HS_WAIT_HI: if (byte_ready)  state_next = HS_IDLE;
            default:                     state_next = HS_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        start_c = (state == HS_ISSUE)   && byte_ready;
        done_c  = (state == HS_WAIT_HI) && byte_ready;
    end

    // Registered engine-side and sequencer-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_start     <= 1'b0;
            byte_continued <= 1'b0;
            byte_tx        <= 8'hFF;
            done           <= 1'b0;
            rx             <= '0;
        end else begin
            byte_start <= start_c;
            done       <= done_c;
            // tx/cont stay put from the start pulse until the next byte is issued
            if ((state == HS_IDLE) && go) begin
                byte_tx        <= tx;
                byte_continued <= cont;
            end
            if (done_c) rx <= byte_rx;
        end
    end

endmodule

// File: rtl/spi_eeprom_sequencer.sv
// Turns one read/write request into 25xx SPI EEPROM byte frames:
//   write: WREN frame, gap, WRITE frame {02, A[15:8], A[7:0], wdata}
//   read : READ frame {03, A[15:8], A[7:0], DUMMY_BYTE}, last rx -> rsp_rdata
// Optional macro SPI_WIP_POLL_EN: after a WRITE frame, poll RDSR {05, DUMMY}
// with gaps until WIP clears (rsp_err=0) or POLL_MAX polls expire (rsp_err=1).
// Ports: clk, rst (sync, active-high); req_* request side; rsp_* response
//        side; byte_* connect to the SPI byte engine.
module spi_eeprom_sequencer
    import spi_eeprom_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       GAP_CYCLES = 4,
    parameter logic [BYTE_W-1:0] DUMMY_BYTE = 8'hFF,
    parameter int unsigned       POLL_MAX   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BYTE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [BYTE_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              byte_start,
    output logic              byte_continued,
    output logic [BYTE_W-1:0] byte_tx,
    input  logic [BYTE_W-1:0] byte_rx,
    input  logic              byte_ready
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              accept_c;
    logic              busy;
    logic [1:0]        idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTE_W-1:0] wdata_q;
    logic [15:0]       addr_wire;
    logic              go_c;
    logic [BYTE_W-1:0] tx_c;
    logic              cont_c;
    logic              last_c;
    logic              hs_done;
    logic [BYTE_W-1:0] hs_rx;

`ifdef SPI_WIP_POLL_EN
    localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
    logic              wr_done_q;
    logic [POLL_W-1:0] poll_cnt;
`endif

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept_c  = req_valid && req_ready;
    assign addr_wire = 16'(addr_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept_c) state_next = req_write ? ST_WREN : ST_FRAME;
            ST_WREN:  if (hs_done)  state_next = ST_GAP;
            ST_GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
`ifdef SPI_WIP_POLL_EN
                    state_next = wr_done_q ? ST_POLL : ST_FRAME;
`else
                    state_next = ST_FRAME;
`endif
                end
            end
            ST_FRAME: begin
                if (hs_done && last_c) begin
`ifdef SPI_WIP_POLL_EN
                    state_next = wr_q ? ST_GAP : ST_RESP;
`else
                    state_next = ST_RESP;
`endif
                end
            end
`ifdef SPI_WIP_POLL_EN
            ST_POLL: begin
                if (hs_done && last_c) begin
                    if (!hs_rx[WIP_BIT] || (poll_cnt >= POLL_W'(POLL_MAX - 1)))
                        state_next = ST_RESP;
                    else
                        state_next = ST_GAP;
                end
            end
`endif
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Byte selection for the current frame position
    always_comb begin
        go_c   = 1'b0;
        tx_c   = DUMMY_BYTE;
        cont_c = 1'b0;
        last_c = 1'b0;
        case (state)
            ST_WREN: begin
                go_c   = !busy;
                tx_c   = CMD_WREN;
                last_c = 1'b1;
            end
            ST_FRAME: begin
                go_c   = !busy;
                cont_c = (idx != 2'd3);
                last_c = (idx == 2'd3);
                case (idx)
                    2'd0:    tx_c = wr_q ? CMD_WRITE : CMD_READ;
                    2'd1:    tx_c = addr_wire[15:8];
                    2'd2:    tx_c = addr_wire[7:0];
                    default: tx_c = wr_q ? wdata_q : DUMMY_BYTE;
                endcase
            end
`ifdef SPI_WIP_POLL_EN
            ST_POLL: begin
                go_c   = !busy;
                cont_c = (idx == 2'd0);
                last_c = (idx != 2'd0);
                tx_c   = (idx == 2'd0) ? CMD_RDSR : DUMMY_BYTE;
            end
`endif
            default: ;
        endcase
    end

    // Request latch, byte progress, gap timer and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            idx       <= 2'd0;
            gap_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept_c) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (go_c)         busy <= 1'b1;
            else if (hs_done) busy <= 1'b0;
            if (state_next != state) idx <= 2'd0;
            else if (hs_done)        idx <= idx + 2'd1;
            if ((state_next == ST_GAP) && (state != ST_GAP)) gap_cnt <= GAP_W'(GAP_CYCLES);
            else if (state == ST_GAP)                        gap_cnt <= gap_cnt - GAP_W'(1);
            rsp_valid <= (state_next == ST_RESP);
            if (state_next == ST_RESP) rsp_rdata <= wr_q ? 8'h00 : hs_rx;
        end
    end

`ifdef SPI_WIP_POLL_EN
    // Poll bookkeeping; the counter saturates at POLL_MAX
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_done_q <= 1'b0;
            poll_cnt  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_done_q <= 1'b0;
                poll_cnt  <= '0;
            end else begin
                if ((state == ST_FRAME) && (state_next == ST_GAP)) wr_done_q <= 1'b1;
                if ((state == ST_POLL) && hs_done && last_c && (poll_cnt != POLL_W'(POLL_MAX)))
                    poll_cnt <= poll_cnt + POLL_W'(1);
            end
            if (state_next == ST_RESP) rsp_err <= (state == ST_POLL) && hs_rx[WIP_BIT];
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    spi_byte_handshake u_hs (
        .clk            (clk),
        .rst            (rst),
        .go             (go_c),
        .tx             (tx_c),
        .cont           (cont_c),
        .done           (hs_done),
        .rx             (hs_rx),
        .byte_start     (byte_start),
        .byte_continued (byte_continued),
        .byte_tx        (byte_tx),
        .byte_rx        (byte_rx),
        .byte_ready     (byte_ready)
    );

endmodule
